op_sequencer: RTL and testbench
===============================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter OP_W, default 3, ALU opcode width.
REQ-002 Parameter DEPTH, default 8, program table entries (power of two, >=2); PTR_W = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 cfg_we  input  1  table write strobe.
REQ-006 cfg_addr  input  PTR_W  table write address.
REQ-007 cfg_op  input  OP_W  table write data.
REQ-008 start  input  1  begin a program run.
REQ-009 len  input  PTR_W+1  number of steps to run, sampled on accepted start.
REQ-010 loop_mode  input  1  repeat program endlessly, sampled on accepted start.
REQ-011 stop  input  1  abort the current run.
REQ-012 op_ready  input  1  ALU accepts the presented op.
REQ-013 alu_op  output  OP_W  current opcode, table[step] in RUN, else 0.
REQ-014 op_valid  output  1  high exactly while in RUN.
REQ-015 step  output  PTR_W  current program index.
REQ-016 busy  output  1  high in RUN and DONE.
REQ-017 done  output  1  one-cycle pulse when a non-loop run completes.
REQ-018 err  output  1  one-cycle pulse on a rejected start.

Function
REQ-019 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-020 IDLE with start and 1<=len<=DEPTH -> RUN next cycle; step=0; len and loop_mode latched.
REQ-021 IDLE with start and (len==0 or len>DEPTH) -> stay IDLE, err=1 for one cycle.
REQ-022 RUN: an op is transferred on any cycle with op_valid and op_ready both high; alu_op is held stable until it is transferred.
REQ-023 A transfer with step<len-1 increments step.
REQ-024 A transfer with step==len-1 and loop_mode=0 -> DONE.
REQ-025 A transfer with step==len-1 and loop_mode=1 -> step wraps to 0 and the FSM stays in RUN.
REQ-026 DONE -> IDLE after one cycle, with done=1 during that cycle.
REQ-027 stop in RUN -> IDLE next cycle with no done pulse; stop overrides a simultaneous transfer, and step is not advanced.
REQ-028 stop outside RUN is ignored.
REQ-029 start while busy is ignored, with no err pulse.
REQ-030 cfg_we is honoured only in IDLE; writes while busy are dropped.
REQ-031 A simultaneous cfg_we and accepted start in IDLE writes the table; the first op presented in RUN uses the updated entry.
REQ-032 Table reads are combinational from registered step; latency from start to first op_valid is one cycle.

Reset
REQ-033 Asserting reset_n low at any time, including mid-run, forces IDLE within the same cycle (asynchronous).
REQ-034 Reset values: step=0, op_valid=0, busy=0, done=0, err=0, alu_op=0, latched len=0, latched loop_mode=0.
REQ-035 Reset loads table[i] = i mod 2^OP_W; default power-up program ADD, SUB, AND, OR, XOR, SHL, SHR, CMP.

Structure
REQ-036 Package op_seq_pkg holds the state encoding (IDLE/RUN/DONE) and the opcode constants ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, CMP=7.
REQ-037 The table is a separate sub-module, op_table: DEPTH x OP_W flops with a reset-to-identity value, one write port and one combinational read port.

Verification
REQ-038 After reset, start with len=8, loop_mode=0, op_ready=1 -> alu_op 0..7 on 8 consecutive cycles, then done pulses once and busy drops.
REQ-039 Write table[0]=5 and table[1]=2, then start with len=2, loop_mode=1, op_ready toggling 1/0 -> alu_op sequence 5,2,5,2, with each value held through its ready-low cycles and no done pulse.
REQ-040 Start with len=0, then start with len=9 (DEPTH=8) -> err pulses on both attempts, busy stays 0.
REQ-041 Start with len=4 and assert stop together with op_ready at step=2 -> IDLE next cycle, step stays 2 at abort, no done pulse.
REQ-042 Assert reset_n low at step=3 of a looping run -> op_valid=0 and step=0 immediately, and the table returns to the identity program.
REQ-043 Assert cfg_we with cfg_addr=0, cfg_op=7 during RUN -> table unchanged; a later run with len=1 outputs alu_op=0.

Source files
------------

// File: rtl/op_seq_pkg.sv
// Shared constants for the op sequencer slice.
// FSM encoding and the default ALU opcode set.
package op_seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

endpackage

// File: rtl/op_table.sv
// Program table: DEPTH x OP_W flops, one write port.
// Reset loads the identity program; reads are combinational.
module op_table #(
  parameter int OP_W  = 3,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [OP_W-1:0]  wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [OP_W-1:0]  rdata_o
);

  logic [OP_W-1:0] mem_q [DEPTH];

  // Table storage: identity on reset, single write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= OP_W'(i);
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/op_sequencer.sv
// Steps through a programmable opcode table, one op per
// accepted valid/ready transfer, with loop and abort.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LEN_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [PTR_W-1:0] cfg_addr,
  input  logic [OP_W-1:0]  cfg_op,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             loop_mode,
  input  logic             stop,
  input  logic             op_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic             op_valid,
  output logic [PTR_W-1:0] step,
  output logic             busy,
  output logic             done,
  output logic             err
);

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] step_q, step_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             loop_q, loop_d;
  logic             err_q, err_d;

  logic             len_ok;
  logic             last;
  logic             tbl_we;
  logic [OP_W-1:0]  tbl_op;

  assign len_ok = (len != '0) &&
                  (len <= LEN_W'(DEPTH));
  assign last   = ({1'b0, step_q} ==
                   (len_q - LEN_W'(1)));

  // Config writes land only while idle.
  assign tbl_we = cfg_we && (state_q == S_IDLE);

  op_table #(
    .OP_W  (OP_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (tbl_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_op),
    .raddr_i (step_q),
    .rdata_o (tbl_op)
  );

  // Next-state: accept/reject start, advance on
  // transfer, stop wins over a same-cycle transfer.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    loop_d  = loop_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = S_RUN;
            step_d  = '0;
            len_d   = len;
            loop_d  = loop_mode;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (op_ready) begin
          if (!last) begin
            step_d = step_q + PTR_W'(1);
          end else if (loop_q) begin
            step_d = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and run-context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
    end
  end

  assign op_valid = (state_q == S_RUN);
  assign busy     = (state_q == S_RUN) ||
                    (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = err_q;
  assign step     = step_q;
  assign alu_op   = op_valid ? tbl_op : '0;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: vector table plus
// hand sequences for reset and table-write corners.
module tb_op_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [2:0] cfg_op;
  logic       start;
  logic [3:0] len;
  logic       loop_mode;
  logic       stop;
  logic       op_ready;
  logic [2:0] alu_op;
  logic       op_valid;
  logic [2:0] step;
  logic       busy;
  logic       done;
  logic       err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       st;
    logic [3:0] ln;
    logic       lp;
    logic       sp;
    logic       rd;
    logic       we;
    logic [2:0] wa;
    logic [2:0] wo;
    logic       e_v;
    logic [2:0] e_op;
    logic [2:0] e_step;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  op_sequencer #(
    .OP_W  (3),
    .DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_op    (cfg_op),
    .start     (start),
    .len       (len),
    .loop_mode (loop_mode),
    .stop      (stop),
    .op_ready  (op_ready),
    .alu_op    (alu_op),
    .op_valid  (op_valid),
    .step      (step),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic st, input logic [3:0] ln,
    input logic lp, input logic sp,
    input logic rd, input logic we,
    input logic [2:0] wa, input logic [2:0] wo,
    input logic ev, input logic [2:0] eop,
    input logic [2:0] es, input logic eb,
    input logic ed, input logic ee);
    vec_t v;
    v.st = st; v.ln = ln; v.lp = lp;
    v.sp = sp; v.rd = rd; v.we = we;
    v.wa = wa; v.wo = wo;
    v.e_v = ev; v.e_op = eop;
    v.e_step = es; v.e_busy = eb;
    v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drv(input logic st,
                     input logic [3:0] ln,
                     input logic lp,
                     input logic sp,
                     input logic rd,
                     input logic we,
                     input logic [2:0] wa,
                     input logic [2:0] wo);
    start     = st;
    len       = ln;
    loop_mode = lp;
    stop      = sp;
    op_ready  = rd;
    cfg_we    = we;
    cfg_addr  = wa;
    cfg_op    = wo;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drv(0, 4'd0, 0, 0, 0, 0, 3'd0, 3'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_in();
    #12;
    chk("rst_valid", 0, op_valid, 0);
    chk("rst_step", 0, step, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_err", 0, err, 0);
    chk("rst_op", 0, alu_op, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // identity run, len 8, no loop
    vecs.push_back(mk(1,8,0,0,1,0,0,0, 1,0,0,1,0,0));
    for (int i = 1; i < 8; i++) begin
      vecs.push_back(mk(0,0,0,0,1,0,0,0,
                        1,3'(i),3'(i),1,0,0));
    end
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 0,0,7,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,7,0,0,0));
    // rejected starts
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,7,0,0,1));
    vecs.push_back(mk(1,9,0,0,0,0,0,0, 0,0,7,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,7,0,0,0));
    // table write, then write+start together
    vecs.push_back(mk(0,0,0,0,0,1,0,5, 0,0,7,0,0,0));
    vecs.push_back(mk(1,2,1,0,1,1,1,2, 1,5,0,1,0,0));
    // loop with ready toggling; busy start ignored
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,5,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 1,2,1,1,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,2,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 1,5,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,5,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 1,2,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 1,2,1,1,0,0));
    // write while busy is dropped
    vecs.push_back(mk(0,0,0,0,0,1,0,7, 1,2,1,1,0,0));
    // stop ends the loop, no done
    vecs.push_back(mk(0,0,0,1,1,0,0,0, 0,0,1,0,0,0));
    // table[0] must still read 5
    vecs.push_back(mk(1,1,0,0,0,0,0,0, 1,5,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 0,0,0,1,1,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    // len 4, stop with ready at step 2
    vecs.push_back(mk(1,4,0,0,0,0,0,0, 1,5,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 1,2,1,1,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0,0, 1,2,2,1,0,0));
    vecs.push_back(mk(0,0,0,1,1,0,0,0, 0,0,2,0,0,0));
    // stop while idle is ignored
    vecs.push_back(mk(0,0,0,1,0,0,0,0, 0,0,2,0,0,0));

    foreach (vecs[i]) begin
      drv(vecs[i].st, vecs[i].ln, vecs[i].lp,
          vecs[i].sp, vecs[i].rd, vecs[i].we,
          vecs[i].wa, vecs[i].wo);
      tick();
      chk("valid", i, op_valid, vecs[i].e_v);
      chk("alu_op", i, alu_op, vecs[i].e_op);
      chk("step", i, step, vecs[i].e_step);
      chk("busy", i, busy, vecs[i].e_busy);
      chk("done", i, done, vecs[i].e_done);
      chk("err", i, err, vecs[i].e_err);
    end

    // async reset mid-run at step 3 of a loop
    drv(1, 4'd8, 1, 0, 1, 0, 3'd0, 3'd0);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_step", 0, step, 3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 0, op_valid, 0);
    chk("mid_rst_step", 0, step, 0);
    chk("mid_rst_busy", 0, busy, 0);
    chk("mid_rst_op", 0, alu_op, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // table is back to identity
    drv(1, 4'd8, 0, 0, 1, 0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      chk("ident_op", i, alu_op, i);
    end
    tick();
    chk("ident_done", 0, done, 1);
    tick();
    chk("ident_idle", 0, busy, 0);

    // write during RUN leaves table untouched
    drv(1, 4'd2, 0, 0, 0, 0, 3'd0, 3'd0);
    tick();
    drv(0, 4'd0, 0, 0, 0, 1, 3'd0, 3'd7);
    tick();
    drv(0, 4'd0, 0, 0, 1, 0, 3'd0, 3'd0);
    tick();
    chk("wr_run_step", 0, step, 1);
    tick();
    chk("wr_run_done", 0, done, 1);
    tick();
    drv(1, 4'd1, 0, 0, 0, 0, 3'd0, 3'd0);
    tick();
    chk("wr_drop_op", 0, alu_op, 0);
    chk("wr_drop_valid", 0, op_valid, 1);
    drv(0, 4'd0, 0, 0, 1, 0, 3'd0, 3'd0);
    tick();
    chk("len1_done", 0, done, 1);
    idle_in();
    tick();
    chk("len1_idle", 0, busy, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
